// File: rtl/truth_sweep_pkg.sv
// truth_sweep_pkg: sweeper FSM states and a sweep-length helper for benches
package truth_sweep_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
   function automatic int sweep_cycles(input int n_in, input int settle);
      return (1 << n_in) * (settle + 1);
   endfunction
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: 8-bit loadable down-counter, expired while the count is zero
module tt_settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       expired
);
   logic [7:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != 8'd0) cnt <= cnt - 8'd1;
   assign expired = cnt == 8'd0;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector to a combinational DUT and scores its output
module truth_table_sweeper
   import truth_sweep_pkg::*;
#(
   parameter int                   N_IN      = 4,
   parameter logic [2**N_IN-1:0]   EXP_TABLE = '0,
   parameter int                   SETTLE    = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic            dut_f,
   output logic [N_IN-1:0] vec_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_valid
);
   localparam state_t     FIRST    = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
   localparam logic [7:0] LOAD_VAL = 8'((SETTLE == 0) ? 0 : SETTLE - 1);
   state_t state, state_next;
   logic   load, expired, launch, last, mismatch;
   assign launch   = (state == ST_IDLE || state == ST_DONE) && start;
   assign last     = &vec_out;
   assign mismatch = dut_f != EXP_TABLE[vec_out];
   tt_settle_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (LOAD_VAL),
      .expired  (expired)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else state <= state_next;
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE, ST_DONE: state_next = start ? FIRST : state;
         ST_SETTLE:        state_next = expired ? ST_SAMPLE : ST_SETTLE;
         ST_SAMPLE:        state_next = last ? ST_DONE : FIRST;
         default:          state_next = ST_IDLE;
      endcase
      if (abort) state_next = ST_IDLE;
      load = state_next == ST_SETTLE && state != ST_SETTLE;
   end
   // abort outranks both a new start and the SAMPLE scoring update
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n || abort) begin
         vec_out          <= '0;
         err_cnt          <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else if (launch) begin
         vec_out          <= '0;
         err_cnt          <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else if (state == ST_SAMPLE) begin
         if (mismatch) begin
            err_cnt <= err_cnt + (N_IN+1)'(1);
            if (!first_fail_valid) begin
               first_fail_vec   <= vec_out;
               first_fail_valid <= 1'b1;
            end
         end
         if (!last) vec_out <= vec_out + N_IN'(1);
      end
   assign busy = state == ST_SETTLE || state == ST_SAMPLE;
   assign done = state == ST_DONE;
   assign pass = done && err_cnt == '0;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboarded random-fault sweeps on two sweeper configurations
module tb_truth_table_sweeper;
   typedef struct {
      int err; int ffv; int ffvalid; int pass; int cycles;
   } exp_t;
   localparam logic [15:0] EXP4 = 16'hA5C3;
   localparam logic [1:0]  EXP1 = 2'b10;
   logic clk = 0, rst_n = 0;
   logic start4 = 0, abort4 = 0, start1 = 0, abort1 = 0;
   logic [15:0] mask4 = '0;
   logic [1:0]  mask1 = '0;
   logic [3:0] vec4, ffv4;
   logic [4:0] err4;
   logic       busy4, done4, pass4, ffvv4, f4;
   logic [0:0] vec1, ffv1;
   logic [1:0] err1;
   logic       busy1, done1, pass1, ffvv1, f1;
   int n_checks = 0, n_fail = 0;
   exp_t q4[$], q1[$];
   int bprev[2], dprev[2], bcnt[2], seen[2];
   always #5 clk = ~clk;
   // reference DUTs reproduce the table, with chosen vectors flipped
   assign f4 = EXP4[vec4] ^ mask4[vec4];
   assign f1 = vec1[0] ^ mask1[vec1];
   truth_table_sweeper #(.N_IN(4), .EXP_TABLE(16'hA5C3), .SETTLE(1)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .dut_f(f4),
      .vec_out(vec4), .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4),
      .first_fail_vec(ffv4), .first_fail_valid(ffvv4));
   truth_table_sweeper #(.N_IN(1), .EXP_TABLE(2'b10), .SETTLE(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_f(f1),
      .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
      .first_fail_vec(ffv1), .first_fail_valid(ffvv1));
   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   function automatic exp_t model(input int n, input int settle, input logic [15:0] m);
      exp_t e;
      e.err = 0; e.ffv = 0; e.ffvalid = 0;
      for (int k = 0; k < (1 << n); k++)
         if (m[k]) begin
            if (e.ffvalid == 0) begin e.ffv = k; e.ffvalid = 1; end
            e.err++;
         end
      e.pass = (e.err == 0);
      e.cycles = (1 << n) * (settle + 1);
      return e;
   endfunction
   task automatic mon(input int id, input logic b, input logic d, input logic p,
                      input int err, input int ffv, input logic ffvv, input int vec, input int last);
      exp_t e;
      if (!rst_n) begin
         bprev[id] = 0; dprev[id] = 0; bcnt[id] = 0;
         return;
      end
      if (b && bprev[id] == 0) bcnt[id] = 1;
      else if (b) bcnt[id]++;
      if (!d) chk($sformatf("u%0d_pass_low_when_not_done", id), p, 0);
      if (d && dprev[id] == 0) begin
         if ((id == 0 ? q4.size() : q1.size()) == 0) chk($sformatf("u%0d_unexpected_done", id), 1, 0);
         else begin
            e = (id == 0) ? q4.pop_front() : q1.pop_front();
            chk($sformatf("u%0d_err_cnt", id), err, e.err);
            chk($sformatf("u%0d_first_fail_vec", id), ffv, e.ffv);
            chk($sformatf("u%0d_first_fail_valid", id), ffvv, e.ffvalid);
            chk($sformatf("u%0d_pass", id), p, e.pass);
            chk($sformatf("u%0d_busy_cycles", id), bcnt[id], e.cycles);
            chk($sformatf("u%0d_vec_out_done", id), vec, last);
         end
         seen[id]++;
      end
      bprev[id] = b; dprev[id] = d;
   endtask
   always @(negedge clk) mon(0, busy4, done4, pass4, err4, ffv4, ffvv4, vec4, 15);
   always @(negedge clk) mon(1, busy1, done1, pass1, err1, ffv1, ffvv1, vec1, 1);
   task automatic wait_seen(input int id, input int target, input string name);
      for (int c = 0; c < 500; c++) begin
         @(negedge clk); #1;
         if (seen[id] >= target) return;
      end
      chk({name, "_timeout"}, seen[id], target);
   endtask
   task automatic sweep4(input logic [15:0] m);
      int t;
      mask4 = m;
      q4.push_back(model(4, 1, m));
      t = seen[0] + 1;
      @(negedge clk) start4 = 1;
      @(negedge clk) start4 = 0;
      wait_seen(0, t, "u4_sweep");
   endtask
   task automatic sweep1(input logic [1:0] m);
      int t;
      mask1 = m;
      q1.push_back(model(1, 0, {14'd0, m}));
      t = seen[1] + 1;
      @(negedge clk) start1 = 1;
      @(negedge clk) start1 = 0;
      wait_seen(1, t, "u1_sweep");
   endtask
   task automatic idle_outputs(input string name);
      chk({name, "_vec_out"}, vec4, 0);
      chk({name, "_busy"}, busy4, 0);
      chk({name, "_done"}, done4, 0);
      chk({name, "_pass"}, pass4, 0);
      chk({name, "_err_cnt"}, err4, 0);
      chk({name, "_first_fail_vec"}, ffv4, 0);
      chk({name, "_first_fail_valid"}, ffvv4, 0);
   endtask
   initial begin
      int t;
      bprev = '{0, 0}; dprev = '{0, 0}; bcnt = '{0, 0}; seen = '{0, 0};
      repeat (3) @(negedge clk);
      idle_outputs("reset");
      rst_n = 1;
      repeat (2) @(negedge clk);
      sweep4(16'h0000);
      sweep4(16'h0020);
      sweep4(16'hFFFF);
      repeat (3) @(negedge clk);
      chk("done_hold", done4, 1);
      chk("vec_out_hold_all_ones", vec4, 15);
      chk("err_cnt_hold", err4, 16);
      for (int i = 0; i < 4; i++) sweep4(16'($urandom));
      mask4 = 16'h0101;
      q4.push_back(model(4, 1, 16'h0101));
      q4.push_back(model(4, 1, 16'h0101));
      t = seen[0] + 2;
      @(negedge clk) start4 = 1;
      wait_seen(0, t, "u4_held_start");
      start4 = 0;
      repeat (3) @(negedge clk);
      chk("held_start_done_stays", done4, 1);
      chk("held_start_no_extra_sweep", q4.size(), 0);
      mask4 = 16'hFFFF;
      @(negedge clk) start4 = 1;
      @(negedge clk) start4 = 0;
      for (int c = 0; c < 100 && vec4 != 7; c++) @(negedge clk);
      chk("abort_reached_vec7", vec4, 7);
      abort4 = 1;
      @(posedge clk); #1;
      abort4 = 0;
      idle_outputs("abort");
      repeat (40) @(negedge clk);
      chk("abort_stays_idle", busy4 | done4, 0);
      @(negedge clk) start4 = 1;
      @(negedge clk) start4 = 0;
      repeat (9) @(negedge clk);
      chk("mid_sweep_busy", busy4, 1);
      #2 rst_n = 0;
      #1 idle_outputs("async_reset");
      @(negedge clk) rst_n = 1;
      repeat (40) @(negedge clk);
      chk("reset_needs_new_start", busy4 | done4, 0);
      sweep1(2'b00);
      sweep1(2'b01);
      sweep1(2'($urandom));
      sweep4(16'($urandom));
      repeat (2) @(negedge clk);
      chk("u4_queue_drained", q4.size(), 0);
      chk("u1_queue_drained", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
